stream_sum4: RTL and testbench
==============================

# stream_sum4

Four-word stream reducer. After reset it reads exactly four 32-bit words from an input channel, sums them into an internal accumulator, writes the sum once to an output channel, then raises `valid` and stays idle until the next reset. It sits between two ready/valid FIFO-style channel blocks, which it drives through their input-side ports.

## Interface

Reset `rst` is synchronous and active-high; the clock is `clk`.

No parameters.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_out_data  in  32  data word presented by input channel
- in_read_ready  in  1  input channel has a word available
- in_write_ready  in  1  input channel write-ready (unused)
- in_read_valid  out  1  read strobe to input channel
- in_in_data  out  32  tied 0
- in_write_valid  out  1  tied 0
- in_rst  out  1  tied 0
- out_out_data  in  32  unused
- out_read_ready  in  1  unused
- out_write_ready  in  1  output channel can accept a word
- out_in_data  out  32  sum word to output channel
- out_write_valid  out  1  write strobe to output channel
- out_read_valid  out  1  tied 0
- out_rst  out  1  tied 0
- valid  out  1  done flag

## Operation

- Registers:
  - `state` (encodings 0–8)
  - `acc` (32-bit)
  - `acc_snap` (32-bit)
  - `i` (32-bit loop index)
  - `last` (1-bit done-compare flag)
  - `first` (marks first loop entry)
- All outputs are combinational decodes of `state`.
- S0 INIT: `acc <= 0`. Go to S1.
- S1 ENTER: `first <= 1`. Go to S2.
- S2 WAIT_IN: next index n = (first ? 0 : i) + 1.
  - If `in_read_ready` = 1: `acc_snap <= acc`, `i <= n`, `last <= (n == 4)`, go to S3.
  - Otherwise hold S2 with no register updates.
- S3 READ: `in_read_valid` = 1. Go to S4.
- S4 ACCUM: `acc <= acc_snap + in_out_data`, with data sampled this cycle (one cycle after the strobe). Go to S5.
- S5 TEST: `first <= 0`. If `last`, go to S6; else go to S2.
- S6 WAIT_OUT: if `out_write_ready` = 1, go to S7; else hold.
- S7 WRITE: `out_write_valid` = 1 and `out_in_data` = `acc`. Go to S8.
- S8 DONE: `valid` = 1. Terminal state; held until `rst`.
- Addition wraps modulo 2^32 unless saturation is configured (see Configuration).
- `out_in_data` is 0 in every state except S7.

## Timing

- Reset: `state`, `acc`, `acc_snap`, `i`, `last` and `first` all clear to 0. All outputs are 0 during and immediately after reset.
- Reset asserted in any state aborts the operation; the next cycle starts from S0.
- Each iteration takes 4 cycles (S2–S5) plus stall cycles in S2.
- With both readies held high from release (cycle 0 = S0):
  - read strobes at cycles 3, 7, 11, 15
  - data sampled at cycles 4, 8, 12, 16
  - `out_write_valid` at cycle 19
  - `valid` rises at cycle 20 and stays high
- `in_read_valid` and `out_write_valid` are single-cycle pulses, exactly 4 and 1 per run respectively.
- `in_read_ready` is examined only in S2 and `out_write_ready` only in S6; both are don't-care elsewhere.
- Dropping `in_read_ready` after S2 has advanced has no effect on the current read.

## Configuration

- `STREAM_SUM4_SAT_EN` defined: the S4 addition saturates. If the unsigned 33-bit sum exceeds 0xFFFFFFFF, `acc` becomes 0xFFFFFFFF.
- `STREAM_SUM4_SAT_EN` undefined: plain 32-bit wrapping add.

## Test plan

- Inputs 1, 2, 3, 4 with readies always high -> strobes at cycles 3/7/11/15; `out_in_data` = 10 with `out_write_valid` at cycle 19; `valid` = 1 from cycle 20 onward.
- `in_read_ready` low for 5 cycles before the second word -> FSM holds S2 and no extra strobes occur; final sum is still correct; write shifts 5 cycles later.
- `out_write_ready` low until cycle 30 -> `out_write_valid` pulses at cycle 31 only; `valid` rises at cycle 32.
- Inputs 0xFFFFFFFF, 2, 0, 0 -> output 1 without the macro; 0xFFFFFFFF with `STREAM_SUM4_SAT_EN`.
- `rst` pulsed after the second read -> all outputs 0; the run restarts from S0; the sum of the next four words is exactly the new inputs (no stale `acc`).
- Run held in S8 for 100 cycles -> no further strobes; `valid` stays 1; the tied outputs stay 0 throughout.

Source files
------------

// File: rtl/stream_sum4.sv
// Four-word stream reducer: reads four words from an input channel, writes their sum once, then holds valid.
// Optional saturating accumulate is selected with `define STREAM_SUM4_SAT_EN.
module stream_sum4 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_out_data,
   input  logic        in_read_ready,
   input  logic        in_write_ready,
   output logic        in_read_valid,
   output logic [31:0] in_in_data,
   output logic        in_write_valid,
   output logic        in_rst,
   input  logic [31:0] out_out_data,
   input  logic        out_read_ready,
   input  logic        out_write_ready,
   output logic [31:0] out_in_data,
   output logic        out_write_valid,
   output logic        out_read_valid,
   output logic        out_rst,
   output logic        valid
);

   typedef enum logic [3:0] {
      S_INIT     = 4'd0,
      S_ENTER    = 4'd1,
      S_WAIT_IN  = 4'd2,
      S_READ     = 4'd3,
      S_ACCUM    = 4'd4,
      S_TEST     = 4'd5,
      S_WAIT_OUT = 4'd6,
      S_WRITE    = 4'd7,
      S_DONE     = 4'd8
   } state_t;

   state_t      state_r, state_next_s;
   logic [31:0] acc_r, acc_snap_r, i_r;
   logic        last_r, first_r;
   logic [31:0] idx_next_s;
   logic        unused_s;

`ifdef STREAM_SUM4_SAT_EN
   function automatic logic [31:0] add_word(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[32]) begin
         add_word = 32'hFFFF_FFFF;
      end else begin
         add_word = s[31:0];
      end
   endfunction
`else
   function automatic logic [31:0] add_word(input logic [31:0] a, input logic [31:0] b);
      add_word = a + b;
   endfunction
`endif

   // The first pass through WAIT_IN ignores whatever i_r holds and counts from zero.
   assign idx_next_s = (first_r ? 32'd0 : i_r) + 32'd1;

   assign in_in_data     = 32'd0;
   assign in_write_valid = 1'b0;
   assign in_rst         = 1'b0;
   assign out_read_valid = 1'b0;
   assign out_rst        = 1'b0;
   assign unused_s       = ^{in_write_ready, out_out_data, out_read_ready};

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_INIT;
         acc_r      <= 32'd0;
         acc_snap_r <= 32'd0;
         i_r        <= 32'd0;
         last_r     <= 1'b0;
         first_r    <= 1'b0;
      end else begin
         state_r <= state_next_s;
         case (state_r)
            S_INIT:  acc_r   <= 32'd0;
            S_ENTER: first_r <= 1'b1;
            S_WAIT_IN: begin
               if (in_read_ready) begin
                  acc_snap_r <= acc_r;
                  i_r        <= idx_next_s;
                  last_r     <= (idx_next_s == 32'd4);
               end
            end
            // Data arrives one cycle after the READ strobe.
            S_ACCUM: acc_r   <= add_word(acc_snap_r, in_out_data);
            S_TEST:  first_r <= 1'b0;
            default: ;
         endcase
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_INIT:  state_next_s = S_ENTER;
         S_ENTER: state_next_s = S_WAIT_IN;
         S_WAIT_IN: begin
            if (in_read_ready) begin
               state_next_s = S_READ;
            end else begin
               state_next_s = S_WAIT_IN;
            end
         end
         S_READ:  state_next_s = S_ACCUM;
         S_ACCUM: state_next_s = S_TEST;
         S_TEST: begin
            if (last_r) begin
               state_next_s = S_WAIT_OUT;
            end else begin
               state_next_s = S_WAIT_IN;
            end
         end
         S_WAIT_OUT: begin
            if (out_write_ready) begin
               state_next_s = S_WRITE;
            end else begin
               state_next_s = S_WAIT_OUT;
            end
         end
         S_WRITE: state_next_s = S_DONE;
         S_DONE:  state_next_s = S_DONE;
         default: state_next_s = S_INIT;
      endcase
   end

   // Output decode of the current state.
   always_comb begin
      in_read_valid   = 1'b0;
      out_write_valid = 1'b0;
      out_in_data     = 32'd0;
      valid           = 1'b0;
      case (state_r)
         S_READ:  in_read_valid = 1'b1;
         S_WRITE: begin
            out_write_valid = 1'b1;
            out_in_data     = acc_r;
         end
         S_DONE:  valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stream_sum4.sv
// Scoreboard bench for stream_sum4: stimulus queues expected strobe cycles and sums, a negedge monitor checks them.
module tb_stream_sum4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_out_data = 32'd0;
   logic        in_read_ready = 1'b0;
   logic        in_write_ready = 1'b0;
   logic        in_read_valid;
   logic [31:0] in_in_data;
   logic        in_write_valid;
   logic        in_rst;
   logic [31:0] out_out_data = 32'd0;
   logic        out_read_ready = 1'b0;
   logic        out_write_ready = 1'b0;
   logic [31:0] out_in_data;
   logic        out_write_valid;
   logic        out_read_valid;
   logic        out_rst;
   logic        valid;

   int          pass_cnt = 0;
   int          chk_cnt = 0;
   int          cyc = 0;
   int          valid_cyc = 1000000;
   logic        rst_seen = 1'b1;
   logic        strobe_seen;
   int          rd_q[$];
   int          wr_cyc_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] word_q[$];
   logic [31:0] tie_s;
   logic [31:0] sat_exp;

   stream_sum4 dut (
      .clk(clk), .rst(rst),
      .in_out_data(in_out_data), .in_read_ready(in_read_ready), .in_write_ready(in_write_ready),
      .in_read_valid(in_read_valid), .in_in_data(in_in_data), .in_write_valid(in_write_valid),
      .in_rst(in_rst),
      .out_out_data(out_out_data), .out_read_ready(out_read_ready), .out_write_ready(out_write_ready),
      .out_in_data(out_in_data), .out_write_valid(out_write_valid), .out_read_valid(out_read_valid),
      .out_rst(out_rst), .valid(valid)
   );

   always #5 clk = ~clk;

   // Cycle counter: cycle 0 is the first cycle after reset release.
   always @(posedge clk) begin
      rst_seen <= rst;
      cyc      <= rst ? 0 : cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Input channel model: a word appears on in_out_data the cycle after a read strobe, junk otherwise.
   initial begin
      forever begin
         @(posedge clk);
         strobe_seen = in_read_valid;
         #1;
         if (strobe_seen && word_q.size() > 0) begin
            in_out_data = word_q.pop_front();
         end else begin
            in_out_data = 32'hBAD0_0000 ^ cyc;
         end
      end
   end

   // Monitor: compares DUT activity against the scoreboard queues.
   always @(negedge clk) begin
      tie_s = in_in_data | {28'd0, in_write_valid, in_rst, out_read_valid, out_rst};
      check("tied outputs", tie_s, 32'd0);
      if (rst_seen) begin
         check("reset strobes/valid", {29'd0, in_read_valid, out_write_valid, valid}, 32'd0);
         check("reset out_in_data", out_in_data, 32'd0);
      end else begin
         check("valid level", {31'd0, valid}, {31'd0, (cyc >= valid_cyc)});
         if (in_read_valid) begin
            if (rd_q.size() == 0) begin
               check("unexpected read strobe", {31'd0, in_read_valid}, 32'd0);
            end else begin
               check("read strobe cycle", cyc, rd_q.pop_front());
            end
         end
         if (out_write_valid) begin
            if (wr_cyc_q.size() == 0) begin
               check("unexpected write strobe", {31'd0, out_write_valid}, 32'd0);
            end else begin
               check("write cycle", cyc, wr_cyc_q.pop_front());
               check("write data", out_in_data, wr_data_q.pop_front());
            end
         end else begin
            check("out_in_data idle", out_in_data, 32'd0);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Runs ncyc cycles, shaping the readies by cycle number.
   task automatic drive(input int ncyc, input int rs_start, input int rs_len, input int wr_hi);
      for (int k = 0; k < ncyc; k++) begin
         in_read_ready   = !(cyc >= rs_start && cyc < rs_start + rs_len);
         out_write_ready = (cyc >= wr_hi);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] d, input int r0, input int r1, input int r2,
                             input int r3, input int wcyc, input logic [31:0] sum);
      word_q = '{a, b, c, d};
      rd_q = '{r0, r1, r2, r3};
      wr_cyc_q.push_back(wcyc);
      wr_data_q.push_back(sum);
      valid_cyc = wcyc + 1;
   endtask

   task automatic check_drained();
      check("reads outstanding", rd_q.size(), 32'd0);
      check("writes outstanding", wr_cyc_q.size(), 32'd0);
   endtask

   initial begin
`ifdef STREAM_SUM4_SAT_EN
      sat_exp = 32'hFFFF_FFFF;
`else
      sat_exp = 32'd1;
`endif
      // Basic run, then held in DONE for over 100 cycles.
      do_reset();
      expect_run(32'd1, 32'd2, 32'd3, 32'd4, 3, 7, 11, 15, 19, 32'd10);
      drive(125, 0, 0, 0);
      check_drained();

      // Input stall of 5 cycles before the second word.
      do_reset();
      expect_run(32'd10, 32'd20, 32'd30, 32'd40, 3, 12, 16, 20, 24, 32'd100);
      drive(35, 6, 5, 0);
      check_drained();

      // Output ready held low until cycle 30.
      do_reset();
      expect_run(32'd7, 32'd8, 32'd9, 32'd11, 3, 7, 11, 15, 31, 32'd35);
      drive(40, 0, 0, 30);
      check_drained();

      // Overflow: wraps to 1, or saturates.
      do_reset();
      expect_run(32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 3, 7, 11, 15, 19, sat_exp);
      drive(25, 0, 0, 0);
      check_drained();

      // Reset after the second read aborts the run; restart must not keep stale acc.
      do_reset();
      valid_cyc = 1000000;
      word_q = '{32'd100, 32'd200, 32'd300, 32'd400};
      rd_q = '{3, 7};
      drive(10, 0, 0, 0);
      check_drained();
      do_reset();
      expect_run(32'd5, 32'd6, 32'd7, 32'd8, 3, 7, 11, 15, 19, 32'd26);
      drive(25, 0, 0, 0);
      check_drained();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
